// File: rtl/bus_ctrl.sv
// Bus master controller: takes one CPU load/store at a time, drives the address
// decoder, routes the access to the selected device and returns data or an error.
module bus_ctrl #(
    parameter int DW      = 16,
    parameter int NDEV    = 7,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [15:0]        req_addr,
    input  logic [DW-1:0]      req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               bus_rd,
    output logic               bus_wr,
    output logic [15:0]        bus_addr,
    output logic [DW-1:0]      bus_wdata,
    input  logic               dec_hit,
    input  logic [2:0]         dec_did,
    output logic [NDEV-1:0]    dev_sel,
    input  logic [NDEV-1:0]    dev_ready,
    input  logic [NDEV*DW-1:0] dev_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          dec_miss;
    logic          sel_ready;
    logic [DW-1:0] sel_rdata;

    assign dec_miss  = !dec_hit || (int'(dec_did) >= NDEV);
    // dev_sel is one-hot, so masking ignores every unselected device's ready.
    assign sel_ready = |(dev_ready & dev_sel);

    // NOTE: a combinational block must assign every output before any branch,
    // otherwise the missing paths infer a latch.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (dev_sel[i]) sel_rdata = sel_rdata | dev_rdata[i*DW +: DW];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            bus_rd    <= 1'b0;
            bus_wr    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            dev_sel   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        bus_addr  <= req_addr;
                        bus_wdata <= req_wdata;
                        bus_rd    <= !req_we;
                        bus_wr    <= req_we;
                        req_ready <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (dec_miss) begin
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        bus_rd    <= 1'b0;
                        bus_wr    <= 1'b0;
                        state     <= S_RESP;
                    end else begin
                        dev_sel <= NDEV'(1) << dec_did;
                        cnt     <= '0;
                        state   <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (sel_ready || cnt == CNT_LAST) begin
                        rsp_err   <= !sel_ready;
                        rsp_rdata <= (sel_ready && bus_rd) ? sel_rdata : '0;
                        rsp_valid <= 1'b1;
                        bus_rd    <= 1'b0;
                        bus_wr    <= 1'b0;
                        dev_sel   <= '0;
                        state     <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/bus_ctrl.md
Name: bus_ctrl

Overview:
- Bus master controller between the CPU load/store request port and the memory-mapped address decoder and devices.
- Accepts one request at a time, drives `bus_rd`/`bus_wr`/`bus_addr` into the decoder, and consumes its `dec_hit`/`dec_did` result.
- Routes the access to the selected device, waits for that device's ready with a timeout, and returns read data or an error to the requester.

Parameters:
- DW, 16, data width of write/read data.
- NDEV, 7, number of mapped devices (did 0..NDEV-1); did 7 = DNONE.
- TIMEOUT, 16, max ACCESS cycles waiting for `dev_ready` before error; must be ≥1.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept request
- req_we  input  1  1 = write, 0 = read
- req_addr  input  16  request address
- req_wdata  input  DW  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  DW  read data (0 for writes/errors)
- rsp_err  output  1  decode miss or timeout
- bus_rd  output  1  read strobe to decoder/devices
- bus_wr  output  1  write strobe to decoder/devices
- bus_addr  output  16  address to decoder/devices
- bus_wdata  output  DW  write data to devices
- dec_hit  input  1  decoder hit (combinational from `bus_*`)
- dec_did  input  3  decoder device id, 7 = none
- dev_sel  output  NDEV  one-hot device select
- dev_ready  input  NDEV  per-device access complete
- dev_rdata  input  NDEV*DW  per-device read data, device i at [i*DW +: DW]

Behaviour:
- **Reset values:** FSM state = IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `bus_rd`=0, `bus_wr`=0, `bus_addr`=0, `bus_wdata`=0, `dev_sel`=0, timeout counter=0.
- **Reset priority:** `rst` wins over everything; a reset mid-transaction aborts it, no response is issued, and all outputs take reset values the next cycle.
- **States:** IDLE, DECODE, ACCESS, RESP.
- **IDLE:**
  - `req_ready`=1; all bus strobes 0.
  - On `req_valid`: latch `req_we`, `req_addr`, `req_wdata`; go to DECODE.
- **DECODE (1 cycle):**
  - `bus_addr`/`bus_wdata` = latched values; `bus_rd` = !we; `bus_wr` = we (never both).
  - `dev_sel` = 0; `dec_hit`/`dec_did` sampled at the end of this cycle.
  - If `dec_hit`=0 or `dec_did`≥NDEV: set `rsp_err`=1, `rsp_rdata`=0, go to RESP.
  - Otherwise latch did, clear counter, go to ACCESS.
- **ACCESS:**
  - Strobes and address held; `dev_sel` = one-hot of latched did.
  - Each cycle: if `dev_ready[did]`=1, capture `rsp_rdata` = `dev_rdata[did]` for reads (0 for writes), set `rsp_err`=0, go to RESP.
  - Else increment counter; if counter reaches TIMEOUT-1 without ready, set `rsp_err`=1, `rsp_rdata`=0, go to RESP.
  - `dev_ready` bits of unselected devices are ignored.
- **RESP:**
  - Strobes and `dev_sel` = 0; `rsp_valid`=1.
  - `rsp_rdata`/`rsp_err` held stable until `rsp_ready`.
  - On `rsp_valid`&`rsp_ready`: go to IDLE, `rsp_valid`=0 the next cycle.
- **Back-pressure:** `req_ready`=0 in all states except IDLE; no new request is accepted while a response is pending.
- **Latency:**
  - Accept at cycle N → DECODE N+1 → ACCESS N+2.
  - If ready at N+2: `rsp_valid` at N+3.
  - Decode miss: `rsp_valid` at N+2.
  - Timeout: `rsp_valid` at N+2+TIMEOUT.
- **Outputs:** all registered.

Test Plan:
- After `rst` for 2 cycles: `req_ready`=1, `rsp_valid`=0, `bus_rd`=`bus_wr`=0, `dev_sel`=0.
- Read `req_addr`=0x2010 with `dev_ready[2]` tied 1 and `dev_rdata[2]`=0xBEEF → `bus_rd`=1 and `bus_addr`=0x2010 for 2 cycles, `dev_sel`=0b0000100, `rsp_valid` 3 cycles after accept with `rsp_rdata`=0xBEEF, `rsp_err`=0.
- Write `req_addr`=0x5FFF, `req_wdata`=0x1234, with `dev_ready[5]` asserted 4 cycles into ACCESS → `bus_wr`=1, `bus_wdata`=0x1234, `dev_sel`=0b0100000 held until ready; `rsp_rdata`=0, `rsp_err`=0.
- Read `req_addr`=0x9000 (decoder `dec_hit`=0, `dec_did`=7) → no `dev_sel`, `rsp_valid` 2 cycles after accept, `rsp_err`=1, `rsp_rdata`=0.
- Read `req_addr`=0x0000 with `dev_ready`=0 and TIMEOUT=16 → `rsp_err`=1 exactly 18 cycles after accept; with `rsp_ready` held 0 for 5 cycles, `rsp_valid`/`rsp_err` stay stable, `req_ready`=0, and a pending `req_valid` is not accepted.
- Assert `rst` during ACCESS of a read to 0x3000 → next cycle all outputs at reset values, no `rsp_valid`; the following request completes normally.
